// File: rtl/sync_fifo_ptr_ctrl.sv
// Pointer, flag and error controller for a synchronous FIFO wrapped around a dual-port RAM.
// Extended pointers carry a wrap bit so that full and empty can be told apart at equal addresses.
module sync_fifo_ptr_ctrl #(
    parameter int DEEPWID = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_req,
    input  logic               rd_req,
    input  logic               flush,
    input  logic               clr_err,
    input  logic [DEEPWID-1:0] cfg_almost_full,
    input  logic [DEEPWID-1:0] cfg_almost_empty,
    output logic               ram_wr_en,
    output logic [DEEPWID-1:0] ram_wr_addr,
    output logic               ram_rd_en,
    output logic [DEEPWID-1:0] ram_rd_addr,
    output logic [DEEPWID:0]   wr_ptr,
    output logic [DEEPWID:0]   rd_ptr,
    output logic               rd_vld,
    output logic               full,
    output logic               empty,
    output logic               almost_full,
    output logic               almost_empty,
    output logic [DEEPWID:0]   fifo_num,
    output logic               overflow,
    output logic               underflow
);

    localparam logic [DEEPWID:0] DEPTH_V = {1'b1, {DEEPWID{1'b0}}};

    logic [DEEPWID:0] wr_ptr_reg, wr_ptr_next;
    logic [DEEPWID:0] rd_ptr_reg, rd_ptr_next;
    logic             rd_vld_reg, rd_vld_next;
    logic             overflow_reg, overflow_next;
    logic             underflow_reg, underflow_next;
    logic [DEEPWID:0] af_thresh;
    logic             ovf_set;
    logic             unf_set;

    // Flags depend only on registered pointers, so request inputs cannot glitch them.
    assign fifo_num     = wr_ptr_reg - rd_ptr_reg;
    assign full         = (fifo_num == DEPTH_V);
    assign empty        = (fifo_num == '0);
    assign af_thresh    = DEPTH_V - {1'b0, cfg_almost_full};
    assign almost_full  = (fifo_num >= af_thresh);
    assign almost_empty = (fifo_num <= {1'b0, cfg_almost_empty});

    // rst_n gates the strobes so the RAM sees no write while the controller is held in reset.
    assign ram_wr_en   = wr_req & ~full & ~flush & rst_n;
    assign ram_rd_en   = rd_req & ~empty & ~flush & rst_n;
    assign ram_wr_addr = wr_ptr_reg[DEEPWID-1:0];
    assign ram_rd_addr = rd_ptr_reg[DEEPWID-1:0];

    assign ovf_set = wr_req & full & ~flush;
    assign unf_set = rd_req & empty & ~flush;

    always_comb begin
        wr_ptr_next    = wr_ptr_reg + {{DEEPWID{1'b0}}, ram_wr_en};
        rd_ptr_next    = rd_ptr_reg + {{DEEPWID{1'b0}}, ram_rd_en};
        rd_vld_next    = ram_rd_en;
        // A new error event in the same cycle as clr_err must not be lost.
        overflow_next  = ovf_set | (overflow_reg & ~clr_err);
        underflow_next = unf_set | (underflow_reg & ~clr_err);
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            rd_vld_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            rd_vld_reg    <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            rd_vld_reg    <= rd_vld_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    assign wr_ptr    = wr_ptr_reg;
    assign rd_ptr    = rd_ptr_reg;
    assign rd_vld    = rd_vld_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_ptr_ctrl.sv
// Directed, table-driven bench for sync_fifo_ptr_ctrl with DEEPWID=3 and thresholds af=2, ae=1.
module tb_sync_fifo_ptr_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_req = 1'b0, rd_req = 1'b0, flush = 1'b0, clr_err = 1'b0;
    logic [2:0] cfg_almost_full = 3'd2, cfg_almost_empty = 3'd1;
    logic       ram_wr_en, ram_rd_en, rd_vld;
    logic [2:0] ram_wr_addr, ram_rd_addr;
    logic [3:0] wr_ptr, rd_ptr, fifo_num;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;

    int checks = 0;
    int errors = 0;

    sync_fifo_ptr_ctrl #(.DEEPWID(3)) dut (
        .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .rd_req(rd_req),
        .flush(flush), .clr_err(clr_err),
        .cfg_almost_full(cfg_almost_full), .cfg_almost_empty(cfg_almost_empty),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
        .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .rd_vld(rd_vld),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .fifo_num(fifo_num), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int wr, rd, fl, clr;     // inputs for this cycle
        int wen, ren, wa, ra;    // expected combinational outputs before the edge
        int num, wp, rp;         // expected pointer state after the edge
        int vld, ovf, unf;       // expected registered status after the edge
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s step %0d got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    // Status flags are derived here from the expected occupancy with af=2, ae=1, DEPTH=8.
    task automatic chk_state(input int idx, input int num, input int wp, input int rp,
                             input int vld, input int ovf, input int unf);
        chk("fifo_num", idx, int'(fifo_num), num);
        chk("wr_ptr", idx, int'(wr_ptr), wp);
        chk("rd_ptr", idx, int'(rd_ptr), rp);
        chk("rd_vld", idx, int'(rd_vld), vld);
        chk("overflow", idx, int'(overflow), ovf);
        chk("underflow", idx, int'(underflow), unf);
        chk("full", idx, int'(full), (num == 8) ? 1 : 0);
        chk("empty", idx, int'(empty), (num == 0) ? 1 : 0);
        chk("almost_full", idx, int'(almost_full), (num >= 6) ? 1 : 0);
        chk("almost_empty", idx, int'(almost_empty), (num <= 1) ? 1 : 0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        wr_req = v.wr[0]; rd_req = v.rd[0]; flush = v.fl[0]; clr_err = v.clr[0];
        #1;
        chk("ram_wr_en", idx, int'(ram_wr_en), v.wen);
        chk("ram_rd_en", idx, int'(ram_rd_en), v.ren);
        chk("ram_wr_addr", idx, int'(ram_wr_addr), v.wa);
        chk("ram_rd_addr", idx, int'(ram_rd_addr), v.ra);
        @(posedge clk); #1;
        chk_state(idx, v.num, v.wp, v.rp, v.vld, v.ovf, v.unf);
        $display("step %0d wr=%0d rd=%0d fl=%0d clr=%0d -> num=%0d wp=%0d rp=%0d vld=%0d ovf=%0d unf=%0d",
                 idx, v.wr, v.rd, v.fl, v.clr, fifo_num, wr_ptr, rd_ptr, rd_vld, overflow, underflow);
    endtask

    initial begin
        // Part A: fill to full, overflow, clear, push+pop at full.
        for (int i = 0; i < 8; i++)
            vq.push_back('{1, 0, 0, 0, 1, 0, i, 0, i + 1, i + 1, 0, 0, 0, 0});
        vq.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 8, 8, 0, 0, 1, 0});
        vq.push_back('{0, 0, 0, 1, 0, 0, 0, 0, 8, 8, 0, 0, 0, 0});
        vq.push_back('{1, 1, 0, 0, 0, 1, 0, 0, 7, 8, 1, 1, 1, 0});
        // Part B (after 20 push+pop cycles, wp=12 rp=5): clear, flush, empty corner cases.
        vq.push_back('{0, 0, 0, 1, 0, 0, 4, 5, 7, 12, 5, 0, 0, 0});
        vq.push_back('{1, 0, 1, 0, 0, 0, 4, 5, 0, 0, 0, 0, 0, 0});
        vq.push_back('{1, 1, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1});
        vq.push_back('{0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1});
        vq.push_back('{0, 0, 0, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0});
        for (int i = 1; i < 8; i++)
            vq.push_back('{1, 0, 0, 0, 1, 0, i, 0, i + 1, i + 1, 0, 0, 0, 0});
        vq.push_back('{1, 0, 0, 1, 0, 0, 0, 0, 8, 8, 0, 0, 1, 0});
        vq.push_back('{0, 1, 0, 0, 0, 1, 0, 0, 7, 8, 1, 1, 1, 0});
        vq.push_back('{0, 1, 0, 0, 0, 1, 0, 1, 6, 8, 2, 1, 1, 0});
        vq.push_back('{0, 0, 0, 0, 0, 0, 0, 2, 6, 8, 2, 0, 1, 0});
        vq.push_back('{0, 0, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0, 1, 0});
        vq.push_back('{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1});

        // Reset state, with a push request held during reset.
        wr_req = 1'b1;
        #12;
        chk("reset_wr_en", -1, int'(ram_wr_en), 0);
        chk("reset_rd_en", -1, int'(ram_rd_en), 0);
        chk_state(-1, 0, 0, 0, 0, 0, 0);
        wr_req = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) run_vec(i, vq[i]);

        // 20 cycles of push+pop at occupancy 7: pointers wrap, flags stay put.
        for (int k = 1; k <= 20; k++) begin
            logic [3:0] ewp, erp;
            ewp = 4'(8 + k);
            erp = 4'(1 + k);
            wr_req = 1'b1; rd_req = 1'b1; flush = 1'b0; clr_err = 1'b0;
            #1;
            chk("stream_wr_en", 100 + k, int'(ram_wr_en), 1);
            chk("stream_rd_en", 100 + k, int'(ram_rd_en), 1);
            @(posedge clk); #1;
            chk_state(100 + k, 7, int'(ewp), int'(erp), 1, 1, 0);
            $display("stream %0d -> num=%0d wp=%0d rp=%0d", k, fifo_num, wr_ptr, rd_ptr);
        end

        for (int i = 11; i < vq.size(); i++) run_vec(i, vq[i]);

        // Asynchronous reset mid-burst, with a read-valid in flight.
        wr_req = 1'b1; rd_req = 1'b0; flush = 1'b0; clr_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        wr_req = 1'b0; rd_req = 1'b1;
        @(posedge clk); #1;
        chk("pre_reset_vld", 200, int'(rd_vld), 1);
        chk("pre_reset_num", 200, int'(fifo_num), 2);
        wr_req = 1'b1; rd_req = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_wr_en", 201, int'(ram_wr_en), 0);
        chk("async_rd_en", 201, int'(ram_rd_en), 0);
        chk_state(201, 0, 0, 0, 0, 0, 0);
        $display("async reset -> num=%0d wp=%0d rp=%0d vld=%0d", fifo_num, wr_ptr, rd_ptr, rd_vld);
        wr_req = 1'b0; rd_req = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ptr_ctrl.md
Name: sync_fifo_ptr_ctrl

Overview:
Write/read-side controller for the synchronous FIFO. It turns requester push/pop requests into qualified RAM enables and addresses, and it owns the extended wr/rd pointers. It derives full/empty/almost flags and occupancy from those pointers, and it flags protocol errors (push-when-full, pop-when-empty). It sits between the requesters and the dual-port RAM, and it produces the pointers that the existing flag logic consumes.

Parameters:
DEEPWID, 3, log2 of FIFO depth; DEPTH = 2**DEEPWID entries; pointers are DEEPWID+1 bits (MSB = wrap bit).

Ports:
clk  input  1  system clock; all state on posedge.
rst_n  input  1  asynchronous active-low reset.
wr_req  input  1  push request.
rd_req  input  1  pop request.
flush  input  1  synchronous flush; empties the FIFO.
clr_err  input  1  clears sticky overflow/underflow.
cfg_almost_full  input  DEEPWID  almost_full threshold (free slots).
cfg_almost_empty  input  DEEPWID  almost_empty threshold (occupancy).
ram_wr_en  output  1  qualified RAM write strobe.
ram_wr_addr  output  DEEPWID  RAM write address = wr_ptr[DEEPWID-1:0].
ram_rd_en  output  1  qualified RAM read strobe.
ram_rd_addr  output  DEEPWID  RAM read address = rd_ptr[DEEPWID-1:0].
wr_ptr  output  DEEPWID+1  extended write pointer.
rd_ptr  output  DEEPWID+1  extended read pointer.
rd_vld  output  1  RAM read data valid (1-cycle RAM latency).
full, empty, almost_full, almost_empty  output  1 each  status flags.
fifo_num  output  DEEPWID+1  occupancy, 0..DEPTH.
overflow  output  1  sticky: push attempted while full.
underflow  output  1  sticky: pop attempted while empty.

Behaviour:
- Reset (async, rst_n=0): wr_ptr=0, rd_ptr=0, rd_vld=0, overflow=0, underflow=0. This gives empty=1, full=0, fifo_num=0, almost_empty=1, and almost_full=(cfg_almost_full==DEPTH-... per formula, i.e. 0 unless thresholds say otherwise). ram_wr_en=ram_rd_en=0 while in reset.
- Enables are combinational from registered state:
  - ram_wr_en = wr_req & ~full & ~flush.
  - ram_rd_en = rd_req & ~empty & ~flush.
- Pointer update on posedge:
  - wr_ptr += ram_wr_en; rd_ptr += ram_rd_en.
  - Both pointers are modulo 2**(DEEPWID+1); wrap from all-ones to 0 toggles the wrap bit naturally.
- Flags and occupancy:
  - fifo_num = wr_ptr - rd_ptr, modulo 2**(DEEPWID+1), width DEEPWID+1.
  - full = (fifo_num == DEPTH); empty = (fifo_num == 0).
  - almost_full = (fifo_num >= DEPTH - cfg_almost_full), computed in DEEPWID+1 bits.
  - almost_empty = (fifo_num <= cfg_almost_empty), zero-extended compare.
  - All are pure functions of the registered pointers: a flag changes the cycle after the causing enable, and never glitches from req inputs.
- Simultaneous push+pop:
  - Neither full nor empty: both accepted, fifo_num unchanged, both pointers advance.
  - Full: pop accepted, push rejected (no write-through); overflow sets.
  - Empty: push accepted, pop rejected (no read-through); underflow sets.
- rd_vld: registered copy of ram_rd_en. It asserts exactly one cycle after each accepted pop, including back-to-back pops.
- Errors:
  - overflow sets on any cycle with wr_req & full & ~flush; underflow sets on rd_req & empty & ~flush.
  - Both hold until clr_err.
  - clr_err and a new set in the same cycle: set wins.
- flush:
  - On posedge with flush=1: wr_ptr <= 0, rd_ptr <= 0, no enables that cycle, rd_vld <= 0.
  - flush has priority over wr_req/rd_req. Error bits are unaffected.
- Reset mid-operation: immediate return to reset values regardless of in-flight requests. rd_vld for a pop accepted just before reset is dropped.
- No state machine beyond the pointer/valid/error registers.

Test Plan:
1. DEEPWID=3, reset, then 8 pushes, rd_req=0 → ram_wr_addr 0..7; after the 8th edge full=1, fifo_num=8, wr_ptr=4'b1000, rd_ptr=0.
2. From full, 9th push with rd_req=0 → ram_wr_en=0, pointers unchanged, overflow=1 next cycle; clr_err pulse → overflow=0.
3. From full, push+pop same cycle → ram_rd_en=1, ram_wr_en=0, fifo_num=7 next cycle, rd_vld=1 the cycle after the pop; then continuous push+pop for 20 cycles → fifo_num stays 7, pointers wrap 4'b1111→4'b0000 with no flag change.
4. Empty FIFO, rd_req=1 with wr_req=1 → write accepted, read rejected, underflow=1, fifo_num=1, rd_vld stays 0.
5. cfg_almost_full=2, cfg_almost_empty=1: push one at a time → almost_empty=1 at fifo_num 0..1 and 0 at 2; almost_full=0 at fifo_num 5 and 1 at 6..8.
6. Load 5 entries, assert flush together with wr_req=1 → no write, next cycle fifo_num=0, empty=1, pointers 0. Separately, drop rst_n mid-burst → outputs return to reset values immediately, without waiting for a clock edge.
